difficulty_select_ctrl: RTL and testbench
=========================================

# difficulty_select_ctrl

Button-driven controller for the difficulty selection screen. It synchronises and debounces the up, down and centre push-buttons and moves a highlighted selection over Easy, Medium and Hard. It drives the `selection` input of the difficulty pixel generator, and on confirmation it latches the chosen difficulty and issues a one-cycle start pulse to the game-state logic.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz). Legal range is 2 or more; the counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- `WRAP`, default 1: 1 means the selection wraps at the ends; 0 means it saturates.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `active` in 1: high while the difficulty screen is displayed.
- `btn_up` in 1: raw, asynchronous button input; 1 = pressed.
- `btn_down` in 1: raw, asynchronous button input; 1 = pressed.
- `btn_center` in 1: raw, asynchronous button input; 1 = pressed.
- `selection` out 2: highlighted entry, registered. 00 = Easy, 01 = Medium, 10 = Hard. The value 11 is never driven.
- `difficulty` out 2: last confirmed difficulty, registered.
- `confirmed` out 1: level output, high from confirmation until `active` falls.
- `start_pulse` out 1: one-cycle pulse on the confirming edge.

## Operation
Each of the three buttons has an identical front end:
- **Synchroniser:** two-flop chain; both flops reset to 0.
- **Debouncer:** a register `stable` (reset 0) and a counter (reset 0).
  - While the synchroniser output differs from `stable`, the counter increments by 1 per cycle.
  - When the counter would reach `DEBOUNCE_CYCLES`, `stable` takes the new level and the counter clears.
  - Any cycle where the synchroniser output equals `stable` clears the counter, so bounce restarts the count.
- **Press event:** `stable` & ~`stable_d`, where `stable_d` is `stable` delayed one cycle. This is a single-cycle event per accepted press. Releases produce no event.

FSM states, reset to IDLE:
- **IDLE:**
  - `confirmed` = 0.
  - Buttons are ignored.
  - When `active` = 1, go to SELECT and load `selection` to 00.
- **SELECT:**
  - Centre press: `difficulty` <= `selection`, `start_pulse` = 1 for that cycle, `confirmed` <= 1, go to DONE. Centre has priority over up and down in the same cycle; the confirmed value is the pre-update `selection`.
  - Up press only: `selection` decrements. At 00 it goes to 10 when `WRAP` = 1, or stays 00 when `WRAP` = 0.
  - Down press only: `selection` increments. At 10 it goes to 00 when `WRAP` = 1, or stays 10 when `WRAP` = 0.
  - Up and down press in the same cycle: no change.
  - `active` = 0 (checked before any button): go to IDLE with no confirmation. `selection` and `difficulty` hold.
- **DONE:**
  - `confirmed` stays 1.
  - All presses are ignored.
  - When `active` = 0, go to IDLE, which clears `confirmed`.
  - `difficulty` holds until the next confirmation.

Reset (synchronous, any state):
- `selection`, `difficulty` = 00.
- `confirmed`, `start_pulse` = 0.
- All synchroniser, `stable`, `stable_d` registers and counters are cleared. A debounce in progress is discarded.
- A button held through reset is accepted as a press after `DEBOUNCE_CYCLES` of stability once reset is released.

## Timing
- Raw rising input first sampled at edge t:
  - Synchroniser output high after edge t+1.
  - `stable` rises at edge t+1+`DEBOUNCE_CYCLES`.
  - `selection`, `confirmed`, `difficulty` and `start_pulse` update at edge t+2+`DEBOUNCE_CYCLES`.
- `start_pulse` lasts exactly one cycle per confirmation.
- All outputs are registered. There is no combinational path from any input to any output.
- IDLE to SELECT: `selection` = 00 one edge after `active` is sampled high.
- `selection` changes at most once per accepted press. Holding a button generates no repeats.

## Test plan
- **Debounce latency** (`DEBOUNCE_CYCLES` = 4, `active` = 1, in SELECT): hold `btn_down` high → `selection` goes 00→01 exactly at edge t+6. There is no further change while the button is held.
- **Bounce rejection:** toggle `btn_up` high 3 cycles, low 1, repeated 5 times, then low → `selection` is unchanged and no `start_pulse` occurs.
- **Wrap vs saturate:** `WRAP` = 1, three down presses from 00 → 01, 10, 00. `WRAP` = 0, three down presses → 01, 10, 10. `WRAP` = 0, one up press from 00 → 00.
- **Confirm:** from `selection` = 10, press centre → `difficulty` = 10, `start_pulse` high one cycle, `confirmed` = 1. A later down press leaves `selection` = 10. `active` low → `confirmed` = 0 on the next edge.
- **Simultaneous events:** up and down accepted on the same cycle → `selection` unchanged. Centre and down on the same cycle at `selection` = 01 → `difficulty` = 01.
- **Reset mid-operation:** assert `reset` one cycle while in DONE with `difficulty` = 10 and a debounce half complete → all outputs are 0 or 00 and the state is IDLE. The half-counted press does not register after reset.

Source files
------------

// File: rtl/difficulty_select_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : difficulty_select_ctrl
// Brief    : Debounced up/down/centre button controller for the difficulty
//            selection screen (Easy/Medium/Hard) with confirm and start pulse.
// Revision : 1.0 - initial release
// ============================================================================
module difficulty_select_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit WRAP            = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       active,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_center,
    output logic [1:0] selection,
    output logic [1:0] difficulty,
    output logic       confirmed,
    output logic       start_pulse
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam int            NB       = 3;
    localparam int            B_UP     = 0;
    localparam int            B_DOWN   = 1;
    localparam int            B_CENTER = 2;

    localparam logic [1:0] SEL_EASY = 2'd0;
    localparam logic [1:0] SEL_HARD = 2'd2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SELECT = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [NB-1:0] w_raw;
    logic [NB-1:0] w_press;

    assign w_raw = {btn_center, btn_down, btn_up};

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_btn
            logic          sync1_q;
            logic          sync2_q;
            logic          stable_q;
            logic          stable_dly_q;
            logic [CW-1:0] cnt_q;

            // Any cycle where the synchronised level matches stable restarts the count.
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_q      <= 1'b0;
                    sync2_q      <= 1'b0;
                    stable_q     <= 1'b0;
                    stable_dly_q <= 1'b0;
                    cnt_q        <= '0;
                end else begin
                    sync1_q      <= w_raw[gi];
                    sync2_q      <= sync1_q;
                    stable_dly_q <= stable_q;
                    if (sync2_q != stable_q) begin
                        if (cnt_q == CNT_LAST) begin
                            stable_q <= sync2_q;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
            end

            assign w_press[gi] = stable_q & ~stable_dly_q;
        end
    endgenerate

    logic [1:0] state_q, state_d;
    logic [1:0] selection_q, selection_d;
    logic [1:0] difficulty_q, difficulty_d;
    logic       confirmed_q, confirmed_d;
    logic       start_pulse_q, start_pulse_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            selection_q   <= SEL_EASY;
            difficulty_q  <= SEL_EASY;
            confirmed_q   <= 1'b0;
            start_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            selection_q   <= selection_d;
            difficulty_q  <= difficulty_d;
            confirmed_q   <= confirmed_d;
            start_pulse_q <= start_pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (active) state_d = S_SELECT;
            S_SELECT: begin
                if (!active)                 state_d = S_IDLE;
                else if (w_press[B_CENTER])  state_d = S_DONE;
            end
            S_DONE:   if (!active) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        selection_d   = selection_q;
        difficulty_d  = difficulty_q;
        start_pulse_d = 1'b0;
        case (state_q)
            S_IDLE: if (active) selection_d = SEL_EASY;
            S_SELECT: begin
                if (active) begin
                    // Centre wins and confirms the value shown before this cycle.
                    if (w_press[B_CENTER]) begin
                        difficulty_d  = selection_q;
                        start_pulse_d = 1'b1;
                    end else if (w_press[B_UP] && !w_press[B_DOWN]) begin
                        if (selection_q == SEL_EASY)
                            selection_d = WRAP ? SEL_HARD : SEL_EASY;
                        else
                            selection_d = selection_q - 2'd1;
                    end else if (w_press[B_DOWN] && !w_press[B_UP]) begin
                        if (selection_q >= SEL_HARD)
                            selection_d = WRAP ? SEL_EASY : SEL_HARD;
                        else
                            selection_d = selection_q + 2'd1;
                    end
                end
            end
            default: ;
        endcase
        confirmed_d = (state_d == S_DONE);
    end

    assign selection   = selection_q;
    assign difficulty  = difficulty_q;
    assign confirmed   = confirmed_q;
    assign start_pulse = start_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_difficulty_select_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_difficulty_select_ctrl
// Brief    : Scoreboard bench driving a wrapping and a saturating instance
//            with identical button stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_difficulty_select_ctrl;

    localparam int DEB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic active = 1'b0;
    logic btn_up = 1'b0;
    logic btn_down = 1'b0;
    logic btn_center = 1'b0;

    logic [1:0] sel_w, dif_w, sel_s, dif_s;
    logic       cnf_w, stp_w, cnf_s, stp_s;

    int errors = 0;
    int checks = 0;
    int pulses_w = 0;
    int pulses_s = 0;
    logic [1:0] q_wrap[$];
    logic [1:0] q_sat[$];

    always #5 clk = ~clk;

    difficulty_select_ctrl #(.DEBOUNCE_CYCLES(DEB), .WRAP(1'b1)) u_dut_wrap (
        .clk(clk), .reset(reset), .active(active),
        .btn_up(btn_up), .btn_down(btn_down), .btn_center(btn_center),
        .selection(sel_w), .difficulty(dif_w), .confirmed(cnf_w), .start_pulse(stp_w)
    );

    difficulty_select_ctrl #(.DEBOUNCE_CYCLES(DEB), .WRAP(1'b0)) u_dut_sat (
        .clk(clk), .reset(reset), .active(active),
        .btn_up(btn_up), .btn_down(btn_down), .btn_center(btn_center),
        .selection(sel_s), .difficulty(dif_s), .confirmed(cnf_s), .start_pulse(stp_s)
    );

    always @(negedge clk) begin
        if (stp_w) pulses_w++;
        if (stp_s) pulses_s++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one debounced press and release; expected selections go to the scoreboard.
    task automatic press(input logic u, input logic d, input logic c,
                         input logic [1:0] ew, input logic [1:0] es);
        q_wrap.push_back(ew);
        q_sat.push_back(es);
        btn_up = u; btn_down = d; btn_center = c;
        tick(DEB + 5);
        btn_up = 1'b0; btn_down = 1'b0; btn_center = 1'b0;
        tick(DEB + 5);
    endtask

    task automatic pop_compare(input string name);
        logic [1:0] ew, es;
        ew = q_wrap.pop_front();
        es = q_sat.pop_front();
        checks++;
        if (sel_w !== ew) begin
            errors++;
            $display("FAIL %s wrap selection: got %b expected %b", name, sel_w, ew);
        end
        checks++;
        if (sel_s !== es) begin
            errors++;
            $display("FAIL %s sat selection: got %b expected %b", name, sel_s, es);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++;
        if ({sel_w, dif_w, cnf_w, stp_w} !== 6'b0) begin
            errors++;
            $display("FAIL reset wrap outputs: got %b expected 000000", {sel_w, dif_w, cnf_w, stp_w});
        end
        checks++;
        if ({sel_s, dif_s, cnf_s, stp_s} !== 6'b0) begin
            errors++;
            $display("FAIL reset sat outputs: got %b expected 000000", {sel_s, dif_s, cnf_s, stp_s});
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_debounce_latency();
        active = 1'b1;
        tick(3);
        btn_down = 1'b1;
        q_wrap.push_back(2'b01);
        q_sat.push_back(2'b01);
        tick(DEB + 2);
        checks++;
        if (sel_w !== 2'b00) begin
            errors++;
            $display("FAIL latency early edge: got %b expected 00", sel_w);
        end
        tick(1);
        pop_compare("latency_exact_edge");
        tick(12);
        checks++;
        if (sel_w !== 2'b01 || sel_s !== 2'b01) begin
            errors++;
            $display("FAIL hold no repeat: got %b/%b expected 01/01", sel_w, sel_s);
        end
        btn_down = 1'b0;
        tick(DEB + 5);
    endtask

    task automatic test_bounce();
        repeat (5) begin
            btn_up = 1'b1; tick(3);
            btn_up = 1'b0; tick(1);
        end
        tick(12);
        checks++;
        if (sel_w !== 2'b01 || sel_s !== 2'b01) begin
            errors++;
            $display("FAIL bounce selection: got %b/%b expected 01/01", sel_w, sel_s);
        end
        checks++;
        if (pulses_w != 0 || pulses_s != 0) begin
            errors++;
            $display("FAIL bounce start_pulse count: got %0d/%0d expected 0/0", pulses_w, pulses_s);
        end
    endtask

    task automatic test_wrap_saturate();
        logic       up_tbl [7] = '{1, 0, 0, 0, 1, 1, 1};
        logic [1:0] ew_tbl [7] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd1, 2'd0};
        logic [1:0] es_tbl [7] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0};
        for (int i = 0; i < 7; i++) begin
            press(up_tbl[i], ~up_tbl[i], 1'b0, ew_tbl[i], es_tbl[i]);
            pop_compare($sformatf("wrap_step%0d", i));
        end
    endtask

    task automatic test_simultaneous();
        press(1'b0, 1'b1, 1'b0, 2'b01, 2'b01);
        pop_compare("sim_down");
        press(1'b1, 1'b1, 1'b0, 2'b01, 2'b01);
        pop_compare("sim_up_down");
        press(1'b0, 1'b1, 1'b1, 2'b01, 2'b01);
        pop_compare("sim_center_down");
        checks++;
        if (dif_w !== 2'b01 || dif_s !== 2'b01) begin
            errors++;
            $display("FAIL sim center difficulty: got %b/%b expected 01/01", dif_w, dif_s);
        end
        checks++;
        if (cnf_w !== 1'b1 || pulses_w != 1 || pulses_s != 1) begin
            errors++;
            $display("FAIL sim confirm: confirmed %b pulses %0d/%0d expected 1 and 1/1", cnf_w, pulses_w, pulses_s);
        end
    endtask

    task automatic test_confirm();
        active = 1'b0;
        tick(1);
        checks++;
        if (cnf_w !== 1'b0 || cnf_s !== 1'b0) begin
            errors++;
            $display("FAIL confirm clear after active low: got %b/%b expected 0/0", cnf_w, cnf_s);
        end
        active = 1'b1;
        tick(2);
        press(1'b0, 1'b1, 1'b0, 2'b01, 2'b01);
        pop_compare("confirm_down1");
        press(1'b0, 1'b1, 1'b0, 2'b10, 2'b10);
        pop_compare("confirm_down2");
        press(1'b0, 1'b0, 1'b1, 2'b10, 2'b10);
        pop_compare("confirm_center");
        checks++;
        if (dif_w !== 2'b10 || dif_s !== 2'b10 || cnf_w !== 1'b1 || cnf_s !== 1'b1) begin
            errors++;
            $display("FAIL confirm outputs: difficulty %b/%b confirmed %b/%b expected 10/10 1/1",
                     dif_w, dif_s, cnf_w, cnf_s);
        end
        checks++;
        if (pulses_w != 2 || pulses_s != 2) begin
            errors++;
            $display("FAIL confirm pulse count: got %0d/%0d expected 2/2", pulses_w, pulses_s);
        end
        press(1'b0, 1'b1, 1'b0, 2'b10, 2'b10);
        pop_compare("done_ignores_down");
        active = 1'b0;
        tick(1);
        checks++;
        if (cnf_w !== 1'b0 || dif_w !== 2'b10) begin
            errors++;
            $display("FAIL exit done: confirmed %b difficulty %b expected 0 and 10", cnf_w, dif_w);
        end
    endtask

    task automatic test_reset_mid();
        active = 1'b1;
        tick(2);
        press(1'b0, 1'b1, 1'b0, 2'b01, 2'b01);
        pop_compare("rm_down1");
        press(1'b0, 1'b1, 1'b0, 2'b10, 2'b10);
        pop_compare("rm_down2");
        press(1'b0, 1'b0, 1'b1, 2'b10, 2'b10);
        pop_compare("rm_center");
        btn_up = 1'b1;
        tick(4);
        reset = 1'b1;
        btn_up = 1'b0;
        tick(1);
        reset = 1'b0;
        checks++;
        if ({sel_w, dif_w, cnf_w, stp_w} !== 6'b0 || {sel_s, dif_s, cnf_s, stp_s} !== 6'b0) begin
            errors++;
            $display("FAIL reset mid outputs: got %b/%b expected 000000/000000",
                     {sel_w, dif_w, cnf_w, stp_w}, {sel_s, dif_s, cnf_s, stp_s});
        end
        tick(14);
        checks++;
        if (sel_w !== 2'b00 || cnf_w !== 1'b0 || pulses_w != 3) begin
            errors++;
            $display("FAIL discarded debounce: selection %b confirmed %b pulses %0d expected 00 0 3",
                     sel_w, cnf_w, pulses_w);
        end
        press(1'b0, 1'b1, 1'b0, 2'b01, 2'b01);
        pop_compare("rm_select_after_reset");
    endtask

    initial begin
        test_reset();
        test_debounce_latency();
        test_bounce();
        test_wrap_saturate();
        test_simultaneous();
        test_confirm();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
